// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO input conditioning path.
//   IRQ_*      : per-pin interrupt type encodings (cfg_irq_type fields)
//   *_DEF      : default widths for pin count, debounce counter and prescaler
//   edge_hit() : selects the edge event(s) that arm a pending flag
package gpio_pkg;

    typedef logic [1:0] irq_type_t;

    localparam irq_type_t IRQ_RISE = 2'b00;
    localparam irq_type_t IRQ_FALL = 2'b01;
    localparam irq_type_t IRQ_BOTH = 2'b10;
    localparam irq_type_t IRQ_LVLH = 2'b11;

    localparam int NPIN_DEF = 8;
    localparam int CNTW_DEF = 8;
    localparam int PSCW_DEF = 16;

    // Level-high is not an edge type and never hits here; it is handled
    // separately by the channel.
    function automatic logic edge_hit(input irq_type_t typ, input logic rise, input logic fall);
        logic hit;
        case (typ)
            IRQ_RISE: hit = rise;
            IRQ_FALL: hit = fall;
            IRQ_BOTH: hit = rise | fall;
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_in_chan.sv
// One GPIO input channel: 2-flop synchronizer, optional tick-based debounce
// filter, edge detector on the filtered value and a sticky pending flag.
// Ports:
//   clk, rst_n   : block clock, asynchronous active-low reset
//   pad_ival     : raw asynchronous pad input
//   tick         : shared sample tick from the prescaler
//   filt_en      : debounce enable for this pin
//   filt_cnt     : ticks a change must persist before it is accepted (0 acts as 1)
//   irq_type     : rise / fall / both / level-high
//   irq_en       : interrupt enable for this pin
//   irq_clr      : write-1 clear pulse for the pending flag
//   gpio_in      : conditioned input value
//   pend         : registered pending flag
//   pend_nxt     : next-state pending flag (lets the top register the irq OR in step)
module gpio_in_chan
    import gpio_pkg::*;
#(
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pad_ival,
    input  logic            tick,
    input  logic            filt_en,
    input  logic [CNTW-1:0] filt_cnt,
    input  logic [1:0]      irq_type,
    input  logic            irq_en,
    input  logic            irq_clr,
    output logic            gpio_in,
    output logic            pend,
    output logic            pend_nxt
);

    logic            sync_q1;
    logic            sync_q2;
    logic            stable;
    logic            stable_d;
    logic            stable_nxt;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;
    logic [CNTW-1:0] cnt_inc;
    logic [CNTW-1:0] thr;
    logic            rise;
    logic            fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pad_ival;
            sync_q2 <= sync_q1;
        end
    end

    always_comb begin
        thr        = (filt_cnt == '0) ? CNTW'(1) : filt_cnt;
        cnt_inc    = (cnt == '1) ? cnt : cnt + CNTW'(1);
        stable_nxt = stable;
        cnt_nxt    = cnt;
        if (!filt_en) begin
            stable_nxt = sync_q2;
            cnt_nxt    = '0;
        end else if (sync_q2 == stable) begin
            cnt_nxt = '0;
        end else if (tick) begin
            // >= so that lowering the threshold mid-count still accepts
            if (cnt_inc >= thr) begin
                stable_nxt = sync_q2;
                cnt_nxt    = '0;
            end else begin
                cnt_nxt = cnt_inc;
            end
        end
    end

    // Edges come from the filtered history only, so changing irq_type can
    // never fabricate an event.
    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

    always_comb begin
        if (irq_type == IRQ_LVLH) begin
            pend_nxt = stable & irq_en;
        end else if (irq_en && edge_hit(irq_type, rise, fall)) begin
            pend_nxt = 1'b1;
        end else if (irq_clr) begin
            pend_nxt = 1'b0;
        end else begin
            pend_nxt = pend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            pend     <= 1'b0;
        end else begin
            stable   <= stable_nxt;
            stable_d <= stable;
            cnt      <= cnt_nxt;
            pend     <= pend_nxt;
        end
    end

    assign gpio_in = stable;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: one gpio_in_chan per pad plus a shared sample-tick
// prescaler and the registered interrupt OR.
// Ports:
//   clk, rst_n     : block clock, asynchronous active-low reset
//   pad_i_ival     : raw pad inputs (already gated by pad input-enable)
//   cfg_presc      : sample tick every cfg_presc+1 clk cycles
//   cfg_filt_en    : per-pin debounce enable
//   cfg_filt_cnt   : debounce threshold in ticks
//   cfg_irq_type   : 2 bits per pin (rise / fall / both / level-high)
//   cfg_irq_en     : per-pin interrupt enable
//   irq_clr        : write-1 pulse clearing pending flags
//   gpio_in        : conditioned input values
//   irq_pend       : pending flags
//   irq            : OR of pending flags, aligned with irq_pend
module gpio_in_cond
    import gpio_pkg::*;
#(
    parameter int NPIN = NPIN_DEF,
    parameter int CNTW = CNTW_DEF,
    parameter int PSCW = PSCW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NPIN-1:0]   pad_i_ival,
    input  logic [PSCW-1:0]   cfg_presc,
    input  logic [NPIN-1:0]   cfg_filt_en,
    input  logic [CNTW-1:0]   cfg_filt_cnt,
    input  logic [2*NPIN-1:0] cfg_irq_type,
    input  logic [NPIN-1:0]   cfg_irq_en,
    input  logic [NPIN-1:0]   irq_clr,
    output logic [NPIN-1:0]   gpio_in,
    output logic [NPIN-1:0]   irq_pend,
    output logic              irq
);

    logic [PSCW-1:0] presc_cnt;
    logic            tick;
    logic [NPIN-1:0] pend_nxt;

    assign tick = (presc_cnt == cfg_presc);

    // A threshold lowered below the running count wraps on the next cycle
    // instead of counting all the way round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (presc_cnt >= cfg_presc) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PSCW'(1);
        end
    end

    for (genvar i = 0; i < NPIN; i++) begin : g_chan
        gpio_in_chan #(
            .CNTW (CNTW)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .pad_ival (pad_i_ival[i]),
            .tick     (tick),
            .filt_en  (cfg_filt_en[i]),
            .filt_cnt (cfg_filt_cnt),
            .irq_type (cfg_irq_type[2*i +: 2]),
            .irq_en   (cfg_irq_en[i]),
            .irq_clr  (irq_clr[i]),
            .gpio_in  (gpio_in[i]),
            .pend     (irq_pend[i]),
            .pend_nxt (pend_nxt[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |pend_nxt;
        end
    end

endmodule

// File: tb/tb_gpio_in_cond.sv
module tb_gpio_in_cond;
    import gpio_pkg::*;

    localparam int NPIN = 8;
    localparam int CNTW = 8;
    localparam int PSCW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NPIN-1:0]   pad_i_ival;
    logic [PSCW-1:0]   cfg_presc;
    logic [NPIN-1:0]   cfg_filt_en;
    logic [CNTW-1:0]   cfg_filt_cnt;
    logic [2*NPIN-1:0] cfg_irq_type;
    logic [NPIN-1:0]   cfg_irq_en;
    logic [NPIN-1:0]   irq_clr;
    logic [NPIN-1:0]   gpio_in;
    logic [NPIN-1:0]   irq_pend;
    logic              irq;

    always #5 clk = ~clk;

    gpio_in_cond #(.NPIN(NPIN), .CNTW(CNTW), .PSCW(PSCW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pad_i_ival   (pad_i_ival),
        .cfg_presc    (cfg_presc),
        .cfg_filt_en  (cfg_filt_en),
        .cfg_filt_cnt (cfg_filt_cnt),
        .cfg_irq_type (cfg_irq_type),
        .cfg_irq_en   (cfg_irq_en),
        .irq_clr      (irq_clr),
        .gpio_in      (gpio_in),
        .irq_pend     (irq_pend),
        .irq          (irq)
    );

    typedef struct packed {
        logic [NPIN-1:0] gi;
        logic [NPIN-1:0] ip;
        logic            irq;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: pad history, accepted value, its previous value,
    // number of ticks the synchronized input has disagreed, pending flags.
    bit m_s1[NPIN];
    bit m_s2[NPIN];
    bit m_stab[NPIN];
    bit m_stabd[NPIN];
    bit m_pend[NPIN];
    int m_run[NPIN];
    int m_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Expected outputs after the coming rising edge, given the inputs now applied.
    task automatic model_step();
        exp_t e;
        bit   tick;
        if (!rst_n) begin
            for (int i = 0; i < NPIN; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_stabd[i] = 0;
                m_pend[i] = 0; m_run[i] = 0;
            end
            m_cyc = 0;
        end else begin
            tick = ((m_cyc % (int'(cfg_presc) + 1)) == int'(cfg_presc));
            for (int i = 0; i < NPIN; i++) begin
                bit sync;
                bit new_stab;
                bit rise;
                bit fall;
                bit hit;
                int thr;
                int t;
                sync     = m_s2[i];
                new_stab = m_stab[i];
                thr      = (cfg_filt_cnt == 0) ? 1 : int'(cfg_filt_cnt);
                if (!cfg_filt_en[i]) begin
                    new_stab = sync;
                    m_run[i] = 0;
                end else if (sync == m_stab[i]) begin
                    m_run[i] = 0;
                end else if (tick) begin
                    m_run[i]++;
                    if (m_run[i] >= thr) begin
                        new_stab = sync;
                        m_run[i] = 0;
                    end
                end
                rise = m_stab[i] && !m_stabd[i];
                fall = !m_stab[i] && m_stabd[i];
                t    = int'(cfg_irq_type[2*i +: 2]);
                if (t == 3) begin
                    m_pend[i] = m_stab[i] && cfg_irq_en[i];
                end else begin
                    hit = (t == 0 && rise) || (t == 1 && fall) || (t == 2 && (rise || fall));
                    if (cfg_irq_en[i] && hit) m_pend[i] = 1;
                    else if (irq_clr[i])      m_pend[i] = 0;
                end
                m_stabd[i] = m_stab[i];
                m_stab[i]  = new_stab;
                m_s2[i]    = m_s1[i];
                m_s1[i]    = pad_i_ival[i];
            end
            m_cyc++;
        end
        e.irq = 1'b0;
        for (int i = 0; i < NPIN; i++) begin
            e.gi[i] = m_stab[i];
            e.ip[i] = m_pend[i];
            e.irq   = e.irq | m_pend[i];
        end
        sb_q.push_back(e);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // Monitor: compares DUT outputs after every rising edge against the queue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_gpio_in", 32'(gpio_in), 32'(e.gi));
            chk("sb_irq_pend", 32'(irq_pend), 32'(e.ip));
            chk("sb_irq", 32'(irq), 32'(e.irq));
        end
    end

    initial begin
        int n;
        bit seen;
        rst_n        = 1'b0;
        pad_i_ival   = '0;
        cfg_presc    = '0;
        cfg_filt_en  = '0;
        cfg_filt_cnt = '0;
        cfg_irq_type = '0;
        cfg_irq_en   = '0;
        irq_clr      = '0;
        @(negedge clk);

        // Reset holds outputs low while pads toggle; release gives 3-clk latency.
        pad_i_ival = 8'hFF;
        for (int k = 0; k < 3; k++) cycle();
        chk("rst_gpio_in", 32'(gpio_in), 0);
        chk("rst_irq_pend", 32'(irq_pend), 0);
        chk("rst_irq", 32'(irq), 0);
        rst_n = 1'b1;
        n = 11;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (gpio_in == 8'hFF) begin n = k; break; end
        end
        chk("rst_release_latency", 32'(n), 3);

        // Debounce accept: ticks on every 4th edge, sync differs from edge 3,
        // fourth tick lands on edge 16.
        pad_i_ival   = '0;
        cfg_presc    = 16'd3;
        cfg_filt_cnt = 8'd4;
        cfg_filt_en  = 8'h01;
        do_reset();
        pad_i_ival[0] = 1'b1;
        n = 41;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (gpio_in[0]) begin n = k; break; end
        end
        chk("debounce_latency", 32'(n), 16);

        // Glitch reject: 10 clk high only reaches 3 ticks.
        pad_i_ival = '0;
        do_reset();
        pad_i_ival[0] = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin cycle(); seen |= gpio_in[0]; end
        pad_i_ival[0] = 1'b0;
        for (int k = 0; k < 30; k++) begin cycle(); seen |= gpio_in[0]; end
        chk("glitch_reject", 32'(seen), 0);
        // A cleared counter needs the full 4 ticks again (edge 16 relative).
        pad_i_ival[0] = 1'b1;
        n = 41;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (gpio_in[0]) begin n = k; break; end
        end
        chk("glitch_counter_cleared", 32'(n), 16);

        // Edge irq on pin1 (rise), fall ignored, clear pulse.
        pad_i_ival   = '0;
        cfg_presc    = '0;
        cfg_filt_en  = '0;
        cfg_irq_type = '0;
        cfg_irq_type[2*2 +: 2] = IRQ_BOTH;
        cfg_irq_type[2*3 +: 2] = IRQ_LVLH;
        cfg_irq_en   = 8'b0000_1110;
        do_reset();
        pad_i_ival[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (gpio_in[1]) break;
        end
        chk("rise_pend_before", 32'(irq_pend[1]), 0);
        cycle();
        chk("rise_pend", 32'(irq_pend[1]), 1);
        chk("rise_irq", 32'(irq), 1);
        pad_i_ival[1] = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
        chk("fall_holds_pend", 32'(irq_pend[1]), 1);
        irq_clr[1] = 1'b1;
        cycle();
        irq_clr = '0;
        chk("clr_pend", 32'(irq_pend[1]), 0);
        chk("clr_irq", 32'(irq), 0);

        // Set/clear collision on pin2: set wins.
        pad_i_ival[2] = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        irq_clr[2] = 1'b1;
        cycle();
        irq_clr = '0;
        chk("collision_set_wins", 32'(irq_pend[2]), 1);
        irq_clr[2] = 1'b1;
        cycle();
        irq_clr = '0;

        // Level-high irq on pin3.
        pad_i_ival[3] = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        chk("level_pend_set", 32'(irq_pend[3]), 1);
        irq_clr[3] = 1'b1;
        cycle();
        irq_clr = '0;
        chk("level_clr_ignored", 32'(irq_pend[3]), 1);
        pad_i_ival[3] = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("level_gpio_fell", 32'(gpio_in[3]), 0);
        chk("level_pend_lag", 32'(irq_pend[3]), 1);
        cycle();
        chk("level_pend_clr", 32'(irq_pend[3]), 0);

        // Randomized rounds against the model.
        for (int r = 0; r < 6; r++) begin
            cfg_presc    = 16'($urandom_range(0, 3));
            cfg_filt_cnt = 8'($urandom_range(0, 3));
            cfg_filt_en  = 8'($urandom);
            cfg_irq_type = 16'($urandom);
            cfg_irq_en   = 8'($urandom);
            do_reset();
            for (int k = 0; k < 400; k++) begin
                pad_i_ival = pad_i_ival ^ 8'($urandom & $urandom & $urandom);
                irq_clr    = 8'($urandom & $urandom & $urandom & $urandom);
                if (k % 50 == 49) begin
                    cfg_irq_type = 16'($urandom);
                    cfg_irq_en   = 8'($urandom);
                    cfg_filt_cnt = 8'($urandom_range(0, 3));
                end
                cycle();
            end
            irq_clr = '0;
        end

        cycle();
        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
